// File: rtl/irq_ctrl.sv
// irq_ctrl: platform interrupt controller mapping NUM_SRC lines into the
// mip/mie range at TRAP_BASE, with per-source enable, edge/level mode and
// polarity, a registered pending vector and a lowest-index-wins request.
//
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   src_i             raw interrupt lines, bit i = trap code TRAP_BASE+i
//   addr_i            register byte address (0x0 PENDING, 0x4 ENABLE,
//                     0x8 MODE, 0xC POLARITY)
//   wr_en_i           write strobe, with wr_data_i and byte enables wr_strb_i
//   rd_en_i           read strobe; rd_data_o/rd_valid_o one cycle later
//   mip_o             registered PENDING&ENABLE placed at bit TRAP_BASE
//   irq_o, irq_id_o   registered request and trap code of the winner
//   ack_i, ack_id_i   trap unit acknowledge of an edge-mode source
//
// Optional macro IRQ_CTRL_SYNC_EN: adds a SYNC_STAGES-flop synchroniser on
// every src_i bit for asynchronous pads; without it src_i is used directly.
module irq_ctrl #(
   parameter int NUM_SRC     = 10,
   parameter int TRAP_BASE   = 16,
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_SRC-1:0]    src_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  wr_en_i,
   input  logic [31:0]           wr_data_i,
   input  logic [3:0]            wr_strb_i,
   input  logic                  rd_en_i,
   output logic [31:0]           rd_data_o,
   output logic                  rd_valid_o,
   output logic [31:0]           mip_o,
   output logic                  irq_o,
   output logic [4:0]            irq_id_o,
   input  logic                  ack_i,
   input  logic [4:0]            ack_id_i
);

   if (NUM_SRC < 1 || NUM_SRC > 16) begin : g_bad_num
      $error("irq_ctrl: NUM_SRC must be in 1..16");
   end
   if (TRAP_BASE + NUM_SRC > 32) begin : g_bad_base
      $error("irq_ctrl: TRAP_BASE+NUM_SRC exceeds 32");
   end
   if (ADDR_WIDTH < 4) begin : g_bad_addr
      $error("irq_ctrl: ADDR_WIDTH must be at least 4");
   end

   localparam logic [ADDR_WIDTH-1:0] A_PEND = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] A_EN   = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] A_MODE = ADDR_WIDTH'(8);
   localparam logic [ADDR_WIDTH-1:0] A_POL  = ADDR_WIDTH'(12);

   logic [NUM_SRC-1:0] src_s;

`ifdef IRQ_CTRL_SYNC_EN
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("irq_ctrl: SYNC_STAGES must be at least 2");
   end

   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         sync_q[0] <= src_i;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign src_s = sync_q[SYNC_STAGES-1];
`else
   localparam int unused_sync_stages = SYNC_STAGES;
   assign src_s = src_i;
`endif

   logic [NUM_SRC-1:0] pend_q;
   logic [NUM_SRC-1:0] en_q;
   logic [NUM_SRC-1:0] mode_q;
   logic [NUM_SRC-1:0] pol_q;
   logic [NUM_SRC-1:0] prev_q;

   logic [NUM_SRC-1:0] pend_nxt;
   logic [NUM_SRC-1:0] en_nxt;
   logic [NUM_SRC-1:0] mode_nxt;
   logic [NUM_SRC-1:0] pol_nxt;
   logic [NUM_SRC-1:0] prev_nxt;

   logic sel_pend;
   logic sel_en;
   logic sel_mode;
   logic sel_pol;

   assign sel_pend = (addr_i == A_PEND);
   assign sel_en   = (addr_i == A_EN);
   assign sel_mode = (addr_i == A_MODE);
   assign sel_pol  = (addr_i == A_POL);

   logic [31:0]        strb_mask;
   logic [NUM_SRC-1:0] wmask;
   logic [NUM_SRC-1:0] wdata;

   assign strb_mask = {{8{wr_strb_i[3]}}, {8{wr_strb_i[2]}},
                       {8{wr_strb_i[1]}}, {8{wr_strb_i[0]}}};
   assign wmask     = strb_mask[NUM_SRC-1:0];
   assign wdata     = wr_data_i[NUM_SRC-1:0] & wmask;

   always_comb begin
      en_nxt   = en_q;
      mode_nxt = mode_q;
      pol_nxt  = pol_q;
      if (wr_en_i && sel_en) begin
         en_nxt = (en_q & ~wmask) | wdata;
      end
      if (wr_en_i && sel_mode) begin
         mode_nxt = (mode_q & ~wmask) | wdata;
      end
      if (wr_en_i && sel_pol) begin
         pol_nxt = (pol_q & ~wmask) | wdata;
      end
   end

   logic [NUM_SRC-1:0] cfg_chg;
   logic [NUM_SRC-1:0] samp;
   logic [NUM_SRC-1:0] samp_nxt;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] w1c;
   logic [NUM_SRC-1:0] ack_clr;
   logic [NUM_SRC-1:0] edge_hold;

   // A mode/polarity change re-arms the edge detector with the sample
   // seen through the new polarity, so flipping a quiet line never fires.
   assign cfg_chg  = (mode_nxt ^ mode_q) | (pol_nxt ^ pol_q);
   assign samp     = src_s ^ pol_q;
   assign samp_nxt = src_s ^ pol_nxt;
   assign rise     = samp & ~prev_q;
   assign w1c      = (wr_en_i && sel_pend) ? wdata : '0;

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ack_clr[i] = ack_i &&
            (32'(ack_id_i) == 32'(TRAP_BASE + i));
      end
   end

   // A new edge wins over a clear arriving in the same cycle.
   assign edge_hold = rise | (pend_q & ~(w1c | ack_clr));

   always_comb begin
      pend_nxt = (mode_q & edge_hold) | (~mode_q & samp);
      pend_nxt = pend_nxt & ~cfg_chg;
      prev_nxt = (samp & ~cfg_chg) | (samp_nxt & cfg_chg);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         en_q   <= '0;
         mode_q <= '0;
         pol_q  <= '0;
         prev_q <= '0;
      end else begin
         pend_q <= pend_nxt;
         en_q   <= en_nxt;
         mode_q <= mode_nxt;
         pol_q  <= pol_nxt;
         prev_q <= prev_nxt;
      end
   end

   logic [NUM_SRC-1:0] act;
   logic               hit;
   logic [4:0]         hit_idx;

   assign act = pend_q & en_q;

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (act[i]) begin
            hit     = 1'b1;
            hit_idx = 5'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mip_o    <= '0;
         irq_o    <= 1'b0;
         irq_id_o <= '0;
      end else begin
         mip_o <= 32'(act) << TRAP_BASE;
         irq_o <= hit;
         if (hit) begin
            irq_id_o <= 5'(TRAP_BASE) + hit_idx;
         end
      end
   end

   logic [31:0] rd_mux;

   // Reads see the registers before any same-cycle write lands.
   always_comb begin
      rd_mux = '0;
      unique case (1'b1)
         sel_pend: rd_mux = 32'(pend_q);
         sel_en:   rd_mux = 32'(en_q);
         sel_mode: rd_mux = 32'(mode_q);
         sel_pol:  rd_mux = 32'(pol_q);
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_o  <= '0;
         rd_valid_o <= 1'b0;
      end else begin
         rd_valid_o <= rd_en_i;
         if (rd_en_i) begin
            rd_data_o <= rd_mux;
         end
      end
   end

   logic unused_bits;
   assign unused_bits = ^{wr_data_i, strb_mask};

endmodule
